// File: rtl/exe_tl_pkg.sv
// Shared definitions for the EXE->TL stage: opcodes, access sizes, occupancy
// states and the registered payload layout.
package exe_tl_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  // Payload fields are sized for the widest legal configuration; narrower
  // instances zero-extend on entry and slice on exit.
  localparam int MAX_XLEN = 64;
  localparam int MAX_REGW = 8;
  localparam int INSN_W   = 32;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic                  cache_en;
    logic                  cache_we;
    logic                  int_we;
    logic                  misaligned;
    logic [MAX_XLEN-1:0]   addr;
    logic [MAX_XLEN/8-1:0] byte_mask;
    logic [MAX_XLEN-1:0]   store_data;
    logic [MAX_REGW-1:0]   write_addr;
    logic [INSN_W-1:0]     instruction;
    logic [MAX_XLEN-1:0]   pc;
  } tl_payload_t;

  function automatic logic [7:0] size_lanes(input logic [1:0] size);
    logic [7:0] lanes;
    unique case (size)
      SIZE_B:  lanes = 8'h01;
      SIZE_H:  lanes = 8'h03;
      SIZE_W:  lanes = 8'h0F;
      default: lanes = 8'hFF;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/exe_tl_memdec.sv
// Combinational memory-op decode: opcode class, access size legality,
// alignment, byte-lane mask and lane-aligned store data.
module exe_tl_memdec
  import exe_tl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0]               opcode_i,
  input  logic [1:0]               size_i,
  input  logic [$clog2(XLEN/8)-1:0] offset_i,
  input  logic                     int_we_i,
  input  logic [XLEN-1:0]          store_data_i,
  output logic                     cache_en_o,
  output logic                     cache_we_o,
  output logic                     int_we_o,
  output logic                     misaligned_o,
  output logic [XLEN/8-1:0]        byte_mask_o,
  output logic [XLEN-1:0]          store_data_o
);

  localparam int LANES = XLEN / 8;
  localparam int OFFW  = $clog2(LANES);

  logic            is_load;
  logic            is_store;
  logic            is_mem;
  logic            size_ok;
  logic            aligned;
  logic            legal;
  logic [7:0]      lanes;
  logic [OFFW-1:0] align_mask;

  always_comb begin
    is_load    = (opcode_i == OPC_LOAD);
    is_store   = (opcode_i == OPC_STORE);
    is_mem     = is_load | is_store;
    lanes      = size_lanes(size_i);
    size_ok    = (XLEN == 64) || (size_i != SIZE_D);
    // Offset bits below the access size must be zero.
    align_mask = OFFW'((4'd1 << size_i) - 4'd1);
    aligned    = (offset_i & align_mask) == '0;
    legal      = is_mem & size_ok & aligned;

    misaligned_o = is_mem & ~(size_ok & aligned);
    cache_en_o   = legal;
    cache_we_o   = legal & is_store;
    int_we_o     = legal & is_load & int_we_i;
    byte_mask_o  = legal ? LANES'(16'(lanes) << offset_i) : '0;
    store_data_o = legal ? (store_data_i << {offset_i, 3'b000}) : '0;
  end

endmodule

// File: rtl/exe_tl_stage.sv
// EXE->TL pipeline register with one-entry skid buffer; memory decode is
// done on entry so every tl_* output comes straight from flops.
module exe_tl_stage
  import exe_tl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              kill_i,
  input  logic              exe_valid_i,
  output logic              exe_ready_o,
  input  logic [XLEN-1:0]   exe_cache_addr_i,
  input  logic [REGW-1:0]   exe_write_addr_i,
  input  logic              exe_int_write_enable_i,
  input  logic [XLEN-1:0]   exe_store_data_i,
  input  logic [31:0]       exe_instruction_i,
  input  logic [XLEN-1:0]   exe_pc_i,
  output logic              tl_valid_o,
  input  logic              tl_ready_i,
  output logic              tl_cache_enable_o,
  output logic              tl_cache_we_o,
  output logic [XLEN-1:0]   tl_cache_addr_o,
  output logic [XLEN/8-1:0] tl_byte_mask_o,
  output logic [XLEN-1:0]   tl_store_data_o,
  output logic [REGW-1:0]   tl_write_addr_o,
  output logic              tl_int_write_enable_o,
  output logic              tl_misaligned_o,
  output logic [31:0]       tl_instruction_o,
  output logic [XLEN-1:0]   tl_pc_o
);

  localparam int LANES = XLEN / 8;
  localparam int OFFW  = $clog2(LANES);

  occ_e        state_q, state_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  tl_payload_t out_q, out_d;
  tl_payload_t skid_q, skid_d;
  tl_payload_t in_pl;

  logic             dec_en;
  logic             dec_we;
  logic             dec_iwe;
  logic             dec_mis;
  logic [LANES-1:0] dec_mask;
  logic [XLEN-1:0]  dec_sdata;
  logic             accept;
  logic             consume;

  exe_tl_memdec #(.XLEN(XLEN)) u_memdec (
    .opcode_i     (exe_instruction_i[6:0]),
    .size_i       (exe_instruction_i[13:12]),
    .offset_i     (exe_cache_addr_i[OFFW-1:0]),
    .int_we_i     (exe_int_write_enable_i),
    .store_data_i (exe_store_data_i),
    .cache_en_o   (dec_en),
    .cache_we_o   (dec_we),
    .int_we_o     (dec_iwe),
    .misaligned_o (dec_mis),
    .byte_mask_o  (dec_mask),
    .store_data_o (dec_sdata)
  );

  always_comb begin
    in_pl             = '0;
    in_pl.cache_en    = dec_en;
    in_pl.cache_we    = dec_we;
    in_pl.int_we      = dec_iwe;
    in_pl.misaligned  = dec_mis;
    in_pl.addr        = MAX_XLEN'(exe_cache_addr_i);
    in_pl.byte_mask   = (MAX_XLEN/8)'(dec_mask);
    in_pl.store_data  = MAX_XLEN'(dec_sdata);
    in_pl.write_addr  = MAX_REGW'(exe_write_addr_i);
    in_pl.instruction = exe_instruction_i;
    in_pl.pc          = MAX_XLEN'(exe_pc_i);
  end

  assign accept  = exe_valid_i & ready_q;
  assign consume = valid_q & tl_ready_i;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (kill_i) begin
      state_d = OCC_EMPTY;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (accept) begin
            out_d   = in_pl;
            state_d = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && consume) begin
            out_d = in_pl;
          end else if (accept) begin
            skid_d  = in_pl;
            state_d = OCC_FULL;
          end else if (consume) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // ready_q is low here, so only a consume can happen.
          if (consume) begin
            out_d   = skid_q;
            state_d = OCC_ONE;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
    valid_d = (state_d != OCC_EMPTY);
    ready_d = (state_d != OCC_FULL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= OCC_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
    out_q  <= out_d;
    skid_q <= skid_d;
  end

  // Payload is only meaningful while valid; outputs read as zero otherwise.
  assign exe_ready_o           = ready_q;
  assign tl_valid_o            = valid_q;
  assign tl_cache_enable_o     = valid_q & out_q.cache_en;
  assign tl_cache_we_o         = valid_q & out_q.cache_we;
  assign tl_int_write_enable_o = valid_q & out_q.int_we;
  assign tl_misaligned_o       = valid_q & out_q.misaligned;
  assign tl_cache_addr_o       = valid_q ? out_q.addr[XLEN-1:0] : '0;
  assign tl_byte_mask_o        = valid_q ? out_q.byte_mask[LANES-1:0] : '0;
  assign tl_store_data_o       = valid_q ? out_q.store_data[XLEN-1:0] : '0;
  assign tl_write_addr_o       = valid_q ? out_q.write_addr[REGW-1:0] : '0;
  assign tl_instruction_o      = valid_q ? out_q.instruction : '0;
  assign tl_pc_o               = valid_q ? out_q.pc[XLEN-1:0] : '0;

endmodule

// File: tb/tb_exe_tl_stage.sv
// Bench for exe_tl_stage (XLEN=32): directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_exe_tl_stage;

  localparam int XLEN = 32;
  localparam int REGW = 5;
  localparam bit [6:0] LD  = 7'b0000011;
  localparam bit [6:0] ST  = 7'b0100011;
  localparam bit [6:0] ALU = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        kill_i = 1'b0;
  logic        exe_valid_i = 1'b0;
  logic        exe_ready_o;
  logic [31:0] exe_cache_addr_i = '0;
  logic [4:0]  exe_write_addr_i = '0;
  logic        exe_int_write_enable_i = 1'b0;
  logic [31:0] exe_store_data_i = '0;
  logic [31:0] exe_instruction_i = '0;
  logic [31:0] exe_pc_i = '0;
  logic        tl_valid_o;
  logic        tl_ready_i = 1'b0;
  logic        tl_cache_enable_o;
  logic        tl_cache_we_o;
  logic [31:0] tl_cache_addr_o;
  logic [3:0]  tl_byte_mask_o;
  logic [31:0] tl_store_data_o;
  logic [4:0]  tl_write_addr_o;
  logic        tl_int_write_enable_o;
  logic        tl_misaligned_o;
  logic [31:0] tl_instruction_o;
  logic [31:0] tl_pc_o;

  always #5 clk = ~clk;

  exe_tl_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst_i),
    .kill_i                 (kill_i),
    .exe_valid_i            (exe_valid_i),
    .exe_ready_o            (exe_ready_o),
    .exe_cache_addr_i       (exe_cache_addr_i),
    .exe_write_addr_i       (exe_write_addr_i),
    .exe_int_write_enable_i (exe_int_write_enable_i),
    .exe_store_data_i       (exe_store_data_i),
    .exe_instruction_i      (exe_instruction_i),
    .exe_pc_i               (exe_pc_i),
    .tl_valid_o             (tl_valid_o),
    .tl_ready_i             (tl_ready_i),
    .tl_cache_enable_o      (tl_cache_enable_o),
    .tl_cache_we_o          (tl_cache_we_o),
    .tl_cache_addr_o        (tl_cache_addr_o),
    .tl_byte_mask_o         (tl_byte_mask_o),
    .tl_store_data_o        (tl_store_data_o),
    .tl_write_addr_o        (tl_write_addr_o),
    .tl_int_write_enable_o  (tl_int_write_enable_o),
    .tl_misaligned_o        (tl_misaligned_o),
    .tl_instruction_o       (tl_instruction_o),
    .tl_pc_o                (tl_pc_o)
  );

  typedef struct {
    bit        en, we, iwe, mis;
    bit [31:0] addr, sdata, instr, pc;
    bit [3:0]  mask;
    bit [4:0]  waddr;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Expected TL entry derived from the architectural rules, not the RTL.
  function automatic exp_t model_entry(input bit [31:0] addr, input bit [31:0] instr,
                                       input bit iwe_req, input bit [31:0] sd,
                                       input bit [4:0] wa, input bit [31:0] pc);
    exp_t      e;
    bit [31:0] sz;
    bit        ld, st, ok;
    ld    = (instr[6:0] == LD);
    st    = (instr[6:0] == ST);
    sz    = 32'd1 << instr[13:12];
    e.mis = (ld || st) && ((sz > 32'd4) || ((addr % sz) != 32'd0));
    ok    = (ld || st) && !e.mis;
    e.en  = ok;
    e.we  = ok && st;
    e.iwe = ok && ld && iwe_req;
    e.mask  = ok ? 4'(((32'd1 << sz) - 32'd1) << (addr % 32'd4)) : 4'h0;
    e.sdata = ok ? (sd << (32'd8 * (addr % 32'd4))) : 32'h0;
    e.addr  = addr;
    e.instr = instr;
    e.pc    = pc;
    e.waddr = wa;
    return e;
  endfunction

  function automatic bit [31:0] mk(input bit [2:0] f3, input bit [6:0] op);
    return {17'h0, f3, 5'h0, op};
  endfunction

  task automatic check_outputs();
    exp_t e;
    check_eq("exe_ready", exe_ready_o, q.size() < 2);
    check_eq("tl_valid", tl_valid_o, q.size() > 0);
    if (q.size() > 0) e = q[0];
    else e = '{default: 0};
    check_eq("ctl", {tl_cache_enable_o, tl_cache_we_o, tl_int_write_enable_o, tl_misaligned_o},
             {e.en, e.we, e.iwe, e.mis});
    check_eq("addr", tl_cache_addr_o, e.addr);
    check_eq("mask", tl_byte_mask_o, e.mask);
    check_eq("sdata", tl_store_data_o, e.sdata);
    check_eq("waddr", tl_write_addr_o, e.waddr);
    check_eq("instr", tl_instruction_o, e.instr);
    check_eq("pc", tl_pc_o, e.pc);
  endtask

  // One cycle: check current outputs, drive new inputs, advance the model.
  task automatic tick(input bit v, input bit rdy, input bit k, input bit r,
                      input bit [31:0] addr, input bit [31:0] instr, input bit iwe,
                      input bit [31:0] sd, input bit [4:0] wa, input bit [31:0] pc);
    bit acc, cons;
    @(negedge clk);
    check_outputs();
    exe_valid_i = v; tl_ready_i = rdy; kill_i = k; rst_i = r;
    exe_cache_addr_i = addr; exe_instruction_i = instr; exe_int_write_enable_i = iwe;
    exe_store_data_i = sd; exe_write_addr_i = wa; exe_pc_i = pc;
    acc  = v && (q.size() < 2);
    cons = (q.size() > 0) && rdy;
    if (r || k) q.delete();
    else begin
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(model_entry(addr, instr, iwe, sd, wa, pc));
    end
  endtask

  task automatic send(input bit [31:0] addr, input bit [31:0] instr, input bit [31:0] sd,
                      input bit iwe, input bit rdy, input bit [31:0] pc);
    tick(1'b1, rdy, 1'b0, 1'b0, addr, instr, iwe, sd, 5'(pc[6:2]), pc);
  endtask

  task automatic idle(input bit rdy);
    tick(1'b0, rdy, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 5'h0, 32'h0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    tick(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, mk(3'b010, LD), 1'b1, 32'h1, 5'd3, 32'h44);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 32'h0);
    after_edge();
    check_eq("rst_ready", exe_ready_o, 1'b1);
    check_eq("rst_valid", tl_valid_o, 1'b0);

    // Aligned word store, accepted on the first edge out of reset
    send(32'h1004, mk(3'b010, ST), 32'hDEADBEEF, 1'b0, 1'b1, 32'h100);
    after_edge();
    check_eq("sw_en_we", {tl_cache_enable_o, tl_cache_we_o, tl_misaligned_o}, 3'b110);
    check_eq("sw_mask", tl_byte_mask_o, 4'b1111);
    check_eq("sw_sdata", tl_store_data_o, 32'hDEADBEEF);

    send(32'h1003, mk(3'b000, ST), 32'h000000AB, 1'b0, 1'b1, 32'h104);
    after_edge();
    check_eq("sb_mask", tl_byte_mask_o, 4'b1000);
    check_eq("sb_sdata", tl_store_data_o, 32'hAB000000);

    send(32'h1001, mk(3'b001, LD), 32'h0, 1'b1, 1'b1, 32'h2000);
    after_edge();
    check_eq("lh_mis", {tl_misaligned_o, tl_cache_enable_o, tl_int_write_enable_o}, 3'b100);
    check_eq("lh_pc", tl_pc_o, 32'h2000);

    send(32'h10, mk(3'b000, ALU), 32'h5, 1'b1, 1'b1, 32'h108);
    after_edge();
    check_eq("alu_ctl", {tl_cache_enable_o, tl_int_write_enable_o, tl_byte_mask_o}, 6'b0);

    // Back-pressure: two held, third offer refused, in-order drain
    idle(1'b1);
    send(32'h200, mk(3'b010, LD), 32'h0, 1'b1, 1'b0, 32'h300);
    send(32'h204, mk(3'b010, LD), 32'h0, 1'b1, 1'b0, 32'h304);
    after_edge();
    check_eq("bp_full_ready", exe_ready_o, 1'b0);
    send(32'h208, mk(3'b010, LD), 32'h0, 1'b1, 1'b0, 32'h308);
    idle(1'b1);
    after_edge();
    check_eq("bp_drain2_pc", tl_pc_o, 32'h304);
    idle(1'b1);
    idle(1'b1);

    // Kill while full with a new offer
    send(32'h400, mk(3'b010, ST), 32'h11, 1'b0, 1'b0, 32'h500);
    send(32'h404, mk(3'b010, ST), 32'h22, 1'b0, 1'b0, 32'h504);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 32'h408, mk(3'b010, ST), 1'b0, 32'h33, 5'd2, 32'h508);
    after_edge();
    check_eq("kill_valid", tl_valid_o, 1'b0);
    check_eq("kill_ready", exe_ready_o, 1'b1);
    idle(1'b1);

    // Reset while full, then immediate acceptance
    send(32'h600, mk(3'b010, LD), 32'h0, 1'b1, 1'b0, 32'h700);
    send(32'h604, mk(3'b010, LD), 32'h0, 1'b1, 1'b0, 32'h704);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 32'h608, mk(3'b010, LD), 1'b1, 32'h0, 5'd4, 32'h708);
    after_edge();
    check_eq("rst2_valid", tl_valid_o, 1'b0);
    check_eq("rst2_pc", tl_pc_o, 32'h0);
    send(32'h60C, mk(3'b010, LD), 32'h0, 1'b1, 1'b1, 32'h70C);
    after_edge();
    check_eq("rst2_resume_pc", tl_pc_o, 32'h70C);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit [31:0] instr;
      bit [31:0] addr;
      instr = $urandom;
      case ($urandom_range(0, 3))
        0:       instr[6:0] = LD;
        1:       instr[6:0] = ST;
        2:       instr[6:0] = ALU;
        default: instr[6:0] = 7'($urandom);
      endcase
      addr = $urandom;
      tick($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
           $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0,
           addr, instr, 1'($urandom), $urandom, 5'($urandom), $urandom);
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
